// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment capture path: segment codes,
// bus width and the digit phase type.
package seven_seg_pkg;

  localparam int SEG_W = 7;

  // Segment codes as {g,f,e,d,c,b,a}, active-high.
  localparam logic [SEG_W-1:0] SEG_0 = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1 = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2 = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3 = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4 = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5 = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6 = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7 = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9 = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_A = 7'h77;
  localparam logic [SEG_W-1:0] SEG_B = 7'h7C;
  localparam logic [SEG_W-1:0] SEG_C = 7'h39;
  localparam logic [SEG_W-1:0] SEG_D = 7'h5E;
  localparam logic [SEG_W-1:0] SEG_E = 7'h79;
  localparam logic [SEG_W-1:0] SEG_F = 7'h71;

  typedef enum logic {PH_HI, PH_LO} phase_t;

endpackage

// File: rtl/seven_seg_capture_decode.sv
// Combinational seven-segment to hex decoder; unknown codes read as 0
// and are flagged through legal.
module seg_decode
  import seven_seg_pkg::*;
(
  input  logic [SEG_W-1:0] segment,
  output logic [3:0]       value,
  output logic             legal
);

  always_comb begin
    value = 4'h0;
    legal = 1'b1;
    case (segment)
      SEG_0: value = 4'h0;
      SEG_1: value = 4'h1;
      SEG_2: value = 4'h2;
      SEG_3: value = 4'h3;
      SEG_4: value = 4'h4;
      SEG_5: value = 4'h5;
      SEG_6: value = 4'h6;
      SEG_7: value = 4'h7;
      SEG_8: value = 4'h8;
      SEG_9: value = 4'h9;
      SEG_A: value = 4'hA;
      SEG_B: value = 4'hB;
      SEG_C: value = 4'hC;
      SEG_D: value = 4'hD;
      SEG_E: value = 4'hE;
      SEG_F: value = 4'hF;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Receive side of the two-digit multiplexed seven-segment link: pairs up
// strobed digits, decodes them and watches for a stalled transmitter.
module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int TIMEOUT = 50000,
  parameter int CBITS   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEG_W-1:0] segment,
  input  logic             sig,
  output logic [13:0]      both7seg,
  output logic [3:0]       digit_hi,
  output logic [3:0]       digit_lo,
  output logic             valid,
  output logic             err,
  output logic             link_lost
);

  phase_t             phase_reg, phase_next;
  logic [SEG_W-1:0]   hold_hi_reg;
  logic [3:0]         hold_dhi_reg;
  logic               hold_legal_reg;
  logic [CBITS-1:0]   wd_reg;
  logic [13:0]        both_reg;
  logic [3:0]         dhi_reg, dlo_reg;
  logic               valid_reg, err_reg, lost_reg;

  logic [3:0]         dec_value;
  logic               dec_legal;
  logic               commit;
  logic               expire;

  // One decoder on the live bus; the high digit's result is registered.
  seg_decode u_dec (
    .segment (segment),
    .value   (dec_value),
    .legal   (dec_legal)
  );

  assign commit = sig && (phase_reg == PH_LO);
  // A strobe in the cycle the counter would reach the limit wins.
  assign expire = !sig && (wd_reg == CBITS'(TIMEOUT - 1));

  always_comb begin
    phase_next = phase_reg;
    if (sig)
      phase_next = (phase_reg == PH_HI) ? PH_LO : PH_HI;
    else if (expire)
      phase_next = PH_HI;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_reg      <= PH_HI;
      hold_hi_reg    <= '0;
      hold_dhi_reg   <= '0;
      hold_legal_reg <= 1'b0;
      wd_reg         <= '0;
      both_reg       <= '0;
      dhi_reg        <= '0;
      dlo_reg        <= '0;
      valid_reg      <= 1'b0;
      err_reg        <= 1'b0;
      lost_reg       <= 1'b0;
    end else begin
      phase_reg <= phase_next;
      valid_reg <= commit;

      if (sig)
        wd_reg <= '0;
      else if (wd_reg != CBITS'(TIMEOUT))
        wd_reg <= wd_reg + CBITS'(1);

      if (sig)
        lost_reg <= 1'b0;
      else if (expire)
        lost_reg <= 1'b1;

      if (sig && phase_reg == PH_HI) begin
        hold_hi_reg    <= segment;
        hold_dhi_reg   <= dec_value;
        hold_legal_reg <= dec_legal;
      end

      if (commit) begin
        both_reg <= {hold_hi_reg, segment};
        dhi_reg  <= hold_dhi_reg;
        dlo_reg  <= dec_value;
        err_reg  <= !(hold_legal_reg && dec_legal);
      end
    end
  end

  assign both7seg  = both_reg;
  assign digit_hi  = dhi_reg;
  assign digit_lo  = dlo_reg;
  assign valid     = valid_reg;
  assign err       = err_reg;
  assign link_lost = lost_reg;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Self-checking bench: directed scenarios plus random strobes, compared
// every cycle against a queue-based model of the digit link.
module tb_seven_seg_capture;

  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  segment;
  logic        sig;
  logic [13:0] both7seg;
  logic [3:0]  digit_hi, digit_lo;
  logic        valid, err, link_lost;

  seven_seg_capture #(.TIMEOUT(TO), .CBITS(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .segment   (segment),
    .sig       (sig),
    .both7seg  (both7seg),
    .digit_hi  (digit_hi),
    .digit_lo  (digit_lo),
    .valid     (valid),
    .err       (err),
    .link_lost (link_lost)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model state
  logic [6:0]  pend[$];
  int          idle;
  logic [13:0] exp_both;
  logic [3:0]  exp_hi, exp_lo;
  logic        exp_valid, exp_err, exp_lost;

  function automatic int lookup(input logic [6:0] s);
    for (int i = 0; i < 16; i++)
      if (tbl[i] == s) return i;
    return -1;
  endfunction

  function automatic logic [3:0] nib(input logic [6:0] s);
    int v;
    v = lookup(s);
    return (v < 0) ? 4'h0 : v[3:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    idle = 0;
    exp_both = '0; exp_hi = '0; exp_lo = '0;
    exp_valid = 0; exp_err = 0; exp_lost = 0;
  endtask

  task automatic model(input logic s, input logic [6:0] seg);
    logic [6:0] hi;
    exp_valid = 1'b0;
    if (s) begin
      idle = 0;
      exp_lost = 1'b0;
      if (pend.size() == 0) begin
        pend.push_back(seg);
      end else begin
        hi = pend.pop_front();
        exp_both  = {hi, seg};
        exp_hi    = nib(hi);
        exp_lo    = nib(seg);
        exp_err   = (lookup(hi) < 0) || (lookup(seg) < 0);
        exp_valid = 1'b1;
      end
    end else begin
      idle++;
      if (idle == TO) begin
        exp_lost = 1'b1;
        pend.delete();
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".both"},  32'(both7seg),  32'(exp_both));
    chk({tag, ".hi"},    32'(digit_hi),  32'(exp_hi));
    chk({tag, ".lo"},    32'(digit_lo),  32'(exp_lo));
    chk({tag, ".valid"}, 32'(valid),     32'(exp_valid));
    chk({tag, ".err"},   32'(err),       32'(exp_err));
    chk({tag, ".lost"},  32'(link_lost), 32'(exp_lost));
  endtask

  task automatic step(input string tag, input logic s, input logic [6:0] seg);
    sig = s;
    segment = seg;
    model(s, seg);
    @(posedge clk);
    #1;
    check_all(tag);
    $display("cycle %s sig=%0d seg=%02h -> both=%04h hi=%0h lo=%0h v=%0d e=%0d l=%0d",
             tag, s, seg, both7seg, digit_hi, digit_lo, valid, err, link_lost);
    sig = 1'b0;
  endtask

  task automatic idle_n(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 7'h00);
  endtask

  task automatic do_reset();
    sig = 1'b0;
    rst = 1'b0;
    #2;
    model_reset();
    chk("rst.both",  32'(both7seg),  32'h0);
    chk("rst.hi",    32'(digit_hi),  32'h0);
    chk("rst.lo",    32'(digit_lo),  32'h0);
    chk("rst.valid", 32'(valid),     32'h0);
    chk("rst.err",   32'(err),       32'h0);
    chk("rst.lost",  32'(link_lost), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    $display("reset applied");
  endtask

  initial begin
    logic [6:0] rs;
    rst = 1'b0;
    sig = 1'b0;
    segment = '0;
    model_reset();
    #1;
    do_reset();

    // Basic pair 1,2
    step("p12a", 1'b1, 7'h06);
    chk("p12a.valid_low", 32'(valid), 32'h0);
    step("p12b", 1'b1, 7'h5B);
    chk("p12.both", 32'(both7seg), 32'h035B);
    chk("p12.hi",   32'(digit_hi), 32'h1);
    chk("p12.lo",   32'(digit_lo), 32'h2);
    chk("p12.valid", 32'(valid),   32'h1);
    step("p12c", 1'b0, 7'h00);
    chk("p12.valid_drop", 32'(valid), 32'h0);

    // Continuous refresh 8/F every 5 cycles
    do_reset();
    for (int k = 0; k < 8; k++) begin
      step("refresh", 1'b1, (k % 2 == 0) ? 7'h7F : 7'h71);
      chk("refresh.valid", 32'(valid), 32'(k % 2));
      idle_n("refresh_idle", 4);
    end
    chk("refresh.hi",   32'(digit_hi),  32'h8);
    chk("refresh.lo",   32'(digit_lo),  32'hF);
    chk("refresh.lost", 32'(link_lost), 32'h0);

    // Illegal high digit, then a legal pair clears err
    step("ill_a", 1'b1, 7'h00);
    step("ill_b", 1'b1, 7'h3F);
    chk("ill.both", 32'(both7seg), 32'h003F);
    chk("ill.err",  32'(err),      32'h1);
    chk("ill.hi",   32'(digit_hi), 32'h0);
    step("ok_a", 1'b1, 7'h07);
    step("ok_b", 1'b1, 7'h77);
    chk("ok.err", 32'(err), 32'h0);

    // Timeout mid-pair
    do_reset();
    step("to_hi", 1'b1, 7'h06);
    idle_n("to_idle", TO);
    chk("to.lost",  32'(link_lost), 32'h1);
    chk("to.valid", 32'(valid),     32'h0);
    step("to_r1", 1'b1, 7'h4F);
    chk("to_r1.lost",  32'(link_lost), 32'h0);
    chk("to_r1.valid", 32'(valid),     32'h0);
    step("to_r2", 1'b1, 7'h66);
    chk("to_r2.valid", 32'(valid),    32'h1);
    chk("to_r2.hi",    32'(digit_hi), 32'h3);
    chk("to_r2.lo",    32'(digit_lo), 32'h4);

    // Strobe just before / exactly at the limit
    idle_n("near19", TO - 2);
    step("near19_s", 1'b1, 7'h3F);
    chk("near19.lost", 32'(link_lost), 32'h0);
    idle_n("near20", TO - 1);
    step("near20_s", 1'b1, 7'h06);
    chk("near20.lost",  32'(link_lost), 32'h0);
    chk("near20.valid", 32'(valid),     32'h1);

    // Reset between HI and LO
    step("rmid_hi", 1'b1, 7'h7F);
    do_reset();
    step("rmid_a", 1'b1, 7'h6D);
    step("rmid_b", 1'b1, 7'h7D);
    chk("rmid.hi", 32'(digit_hi), 32'h5);
    chk("rmid.lo", 32'(digit_lo), 32'h6);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        do_reset();
      end else if (r < 6) begin
        idle_n("rnd_gap", $urandom_range(15, 25));
      end else begin
        if ($urandom_range(0, 9) < 8) rs = tbl[$urandom_range(0, 15)];
        else rs = 7'($urandom_range(0, 127));
        step("rnd", 1'($urandom_range(0, 1)), rs);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
